// File: rtl/perf_monitor_if.sv
// Bundle of the monitored channel bus, run control and readout port of perf_monitor.
// The master modport is the driving side (system/bench), slave is the monitor itself.
interface perf_monitor_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CMD_W    = 3,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned CH_SEL_W = 4
) ();

  logic [NUM_CH*CMD_W-1:0] ch_cmd;
  logic [NUM_CH-1:0]       ch_done;
  logic                    stop;
  logic                    clear;
  logic                    rd_en;
  logic [CH_SEL_W-1:0]     rd_ch;
  logic [1:0]              rd_field;
  logic                    rd_valid;
  logic [CNT_W-1:0]        rd_data;
  logic                    running;

  modport master (
    output ch_cmd, ch_done, stop, clear, rd_en, rd_ch, rd_field,
    input  rd_valid, rd_data, running
  );

  modport slave (
    input  ch_cmd, ch_done, stop, clear, rd_en, rd_ch, rd_field,
    output rd_valid, rd_data, running
  );

endinterface

// File: rtl/perf_monitor.sv
// Cycle and per-channel transaction statistics (count, latency sum, max latency) with
// run/stop control and a registered one-cycle-latency readout port. All counters saturate.
module perf_monitor #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CMD_W    = 3,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned CH_SEL_W = 4
) (
  input logic           clk,
  input logic           reset,
  perf_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StRun, StStop} state_e;

  state_e state_q, state_d;
  logic   counting;

  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic             inflight_q [NUM_CH];
  logic             inflight_d [NUM_CH];
  logic [CNT_W-1:0] timer_q    [NUM_CH];
  logic [CNT_W-1:0] timer_d    [NUM_CH];
  logic [CNT_W-1:0] txn_cnt_q  [NUM_CH];
  logic [CNT_W-1:0] txn_cnt_d  [NUM_CH];
  logic [CNT_W-1:0] lat_sum_q  [NUM_CH];
  logic [CNT_W-1:0] lat_sum_d  [NUM_CH];
  logic [CNT_W-1:0] lat_max_q  [NUM_CH];
  logic [CNT_W-1:0] lat_max_d  [NUM_CH];
  logic [CNT_W-1:0] latency    [NUM_CH];
  logic [CNT_W:0]   sum_ext    [NUM_CH];

  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] rd_value;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CntMax) ? x : x + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Run/stop FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (!bus.clear && bus.stop) state_d = StStop;
      StStop:  if (bus.clear) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    bus.running = (state_q == StRun);
    counting    = (state_q == StRun);
  end

  // ---------------------------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (bus.clear) begin
      cycle_cnt_d = '0;
    end else if (counting) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      inflight_d[i] = inflight_q[i];
      timer_d[i]    = timer_q[i];
      txn_cnt_d[i]  = txn_cnt_q[i];
      lat_sum_d[i]  = lat_sum_q[i];
      lat_max_d[i]  = lat_max_q[i];
      latency[i]    = sat_inc(timer_q[i]);
      sum_ext[i]    = {1'b0, lat_sum_q[i]} + {1'b0, latency[i]};

      if (bus.clear) begin
        // A clear abandons any open transaction along with the statistics.
        inflight_d[i] = 1'b0;
        timer_d[i]    = '0;
        txn_cnt_d[i]  = '0;
        lat_sum_d[i]  = '0;
        lat_max_d[i]  = '0;
      end else if (counting) begin
        if (!inflight_q[i]) begin
          if (bus.ch_cmd[i*CMD_W +: CMD_W] != '0) begin
            inflight_d[i] = 1'b1;
            timer_d[i]    = '0;
            txn_cnt_d[i]  = sat_inc(txn_cnt_q[i]);
          end
        end else if (bus.ch_done[i]) begin
          inflight_d[i] = 1'b0;
          lat_sum_d[i]  = sum_ext[i][CNT_W] ? CntMax : sum_ext[i][CNT_W-1:0];
          if (latency[i] > lat_max_q[i]) begin
            lat_max_d[i] = latency[i];
          end
        end else begin
          timer_d[i] = sat_inc(timer_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        inflight_q[i] <= 1'b0;
        timer_q[i]    <= '0;
        txn_cnt_q[i]  <= '0;
        lat_sum_q[i]  <= '0;
        lat_max_q[i]  <= '0;
      end
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        inflight_q[i] <= inflight_d[i];
        timer_q[i]    <= timer_d[i];
        txn_cnt_q[i]  <= txn_cnt_d[i];
        lat_sum_q[i]  <= lat_sum_d[i];
        lat_max_q[i]  <= lat_max_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Readout: samples pre-update contents, answers one cycle later
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    rd_value = '0;
    if (bus.rd_field == 2'd3) begin
      rd_value = cycle_cnt_q;
    end else begin
      // Out-of-range channel indices match no entry and read as zero.
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.rd_ch == CH_SEL_W'(i)) begin
          case (bus.rd_field)
            2'd0:    rd_value = txn_cnt_q[i];
            2'd1:    rd_value = lat_sum_q[i];
            2'd2:    rd_value = lat_max_q[i];
            default: rd_value = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = bus.rd_en ? rd_value : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: readout expectations are queued at request time and
// compared when rd_valid returns; a second instance with 4-bit counters covers saturation.
module tb_perf_monitor;

  logic clk = 1'b0;
  logic reset;
  logic reset4;

  always #5 clk = ~clk;

  perf_monitor_if #(.NUM_CH(2), .CMD_W(3), .CNT_W(32), .CH_SEL_W(4)) b ();
  perf_monitor_if #(.NUM_CH(2), .CMD_W(3), .CNT_W(4), .CH_SEL_W(4)) b4 ();

  perf_monitor #(.NUM_CH(2), .CMD_W(3), .CNT_W(32), .CH_SEL_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  perf_monitor #(.NUM_CH(2), .CMD_W(3), .CNT_W(4), .CH_SEL_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (b4)
  );

  int n_total = 0;
  int n_pass  = 0;

  string       tq  [$];
  logic [31:0] vq  [$];
  string       tq4 [$];
  logic [31:0] vq4 [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one readout request this cycle and queue its expected answer.
  task automatic rd(input bit d4, input int ch, input int field, input logic [31:0] exp,
                    input string tag);
    logic [3:0] c;
    logic [1:0] f;
    c = ch[3:0];
    f = field[1:0];
    if (d4) begin
      b4.rd_en = 1'b1; b4.rd_ch = c; b4.rd_field = f;
      tq4.push_back(tag); vq4.push_back(exp);
    end else begin
      b.rd_en = 1'b1; b.rd_ch = c; b.rd_field = f;
      tq.push_back(tag); vq.push_back(exp);
    end
    @(negedge clk);
  endtask

  task automatic rd_end();
    b.rd_en  = 1'b0;
    b4.rd_en = 1'b0;
    tick(2);
  endtask

  // Scoreboards: every rd_valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (b.rd_valid === 1'b1) begin
      if (vq.size() == 0) chk("spurious_rd_valid", 32'd1, 32'd0);
      else chk(tq.pop_front(), b.rd_data, vq.pop_front());
    end
    if (b4.rd_valid === 1'b1) begin
      if (vq4.size() == 0) chk("spurious_rd_valid4", 32'd1, 32'd0);
      else chk(tq4.pop_front(), 32'(b4.rd_data), vq4.pop_front());
    end
  end

  initial begin
    reset = 1'b1; reset4 = 1'b1;
    b.ch_cmd = '0; b.ch_done = '0; b.stop = 0; b.clear = 0; b.rd_en = 0; b.rd_ch = '0;
    b.rd_field = '0;
    b4.ch_cmd = '0; b4.ch_done = '0; b4.stop = 0; b4.clear = 0; b4.rd_en = 0; b4.rd_ch = '0;
    b4.rd_field = '0;

    // 1: reset, 10 run cycles, stop cycle also counted
    tick(2);
    reset = 1'b0; reset4 = 1'b0;
    chk("reset_running", 32'(b.running), 32'd1);
    chk("reset_rd_valid", 32'(b.rd_valid), 32'd0);
    chk("reset_rd_data", b.rd_data, 32'd0);
    tick(10);
    b.stop = 1'b1; tick(1); b.stop = 1'b0;
    chk("stop_running", 32'(b.running), 32'd0);
    rd(0, 0, 3, 32'd11, "t1_cycle_cnt");
    rd(0, 0, 0, 32'd0, "t1_txn_cnt0");
    rd_end();
    chk("rd_valid_idle", 32'(b.rd_valid), 32'd0);

    // 2: two ch0 transactions, latencies 3 and 1; idle done pulse ignored
    b.clear = 1'b1; tick(1); b.clear = 1'b0;
    chk("clear_running", 32'(b.running), 32'd1);
    b.ch_cmd[2:0] = 3'd1; tick(1);
    b.ch_cmd[2:0] = 3'd0; tick(2);
    b.ch_done[0] = 1'b1; tick(1);
    tick(1);
    b.ch_done[0] = 1'b0; b.ch_cmd[2:0] = 3'd5; tick(1);
    b.ch_cmd[2:0] = 3'd0; b.ch_done[0] = 1'b1; tick(1);
    b.ch_done[0] = 1'b0;
    b.stop = 1'b1; tick(1); b.stop = 1'b0;
    rd(0, 0, 0, 32'd2, "t2_txn_cnt");
    rd(0, 0, 1, 32'd4, "t2_lat_sum");
    rd(0, 0, 2, 32'd3, "t2_lat_max");
    rd(0, 0, 3, 32'd8, "t2_cycle_cnt");
    rd(0, 1, 0, 32'd0, "t2_txn_cnt1");
    rd(0, 2, 0, 32'd0, "t2_oob_ch2");
    rd(0, 3, 1, 32'd0, "t2_oob_ch3");
    rd_end();

    // 3: ch1 command held through the transaction, done at start+7
    b.clear = 1'b1; tick(1); b.clear = 1'b0;
    b.ch_cmd[5:3] = 3'd3; tick(7);
    b.ch_done[1] = 1'b1; tick(1);
    b.ch_cmd[5:3] = 3'd0; b.ch_done[1] = 1'b0;
    b.stop = 1'b1; tick(1); b.stop = 1'b0;
    rd(0, 1, 0, 32'd1, "t3_txn_cnt");
    rd(0, 1, 1, 32'd7, "t3_lat_sum");
    rd(0, 1, 2, 32'd7, "t3_lat_max");
    rd_end();

    // 4: 4-bit counters saturate
    reset4 = 1'b1; tick(1); reset4 = 1'b0;
    tick(20);
    b4.stop = 1'b1; tick(1); b4.stop = 1'b0;
    rd(1, 0, 3, 32'd15, "t4_cycle_sat");
    rd_end();
    b4.clear = 1'b1; tick(1); b4.clear = 1'b0;
    repeat (2) begin
      b4.ch_cmd[2:0] = 3'd1; tick(1);
      b4.ch_cmd[2:0] = 3'd0; tick(8);
      b4.ch_done[0] = 1'b1; tick(1);
      b4.ch_done[0] = 1'b0;
    end
    b4.stop = 1'b1; tick(1); b4.stop = 1'b0;
    rd(1, 0, 0, 32'd2, "t4_txn_cnt");
    rd(1, 0, 1, 32'd15, "t4_lat_sum_sat");
    rd(1, 0, 2, 32'd9, "t4_lat_max");
    rd_end();
    b4.clear = 1'b1; tick(1); b4.clear = 1'b0;
    b4.ch_cmd[2:0] = 3'd2; tick(1);
    b4.ch_cmd[2:0] = 3'd0; tick(19);
    b4.ch_done[0] = 1'b1; tick(1); b4.ch_done[0] = 1'b0;
    b4.stop = 1'b1; tick(1); b4.stop = 1'b0;
    rd(1, 0, 2, 32'd15, "t4_timer_sat");
    rd_end();

    // 5: stop with ch0 in flight, hold, then clear
    b.clear = 1'b1; tick(1); b.clear = 1'b0;
    b.ch_cmd[2:0] = 3'd1; tick(1);
    b.ch_cmd[2:0] = 3'd0; tick(2);
    b.stop = 1'b1; tick(1); b.stop = 1'b0;
    tick(5);
    rd(0, 0, 0, 32'd1, "t5_frozen_txn");
    rd(0, 0, 1, 32'd0, "t5_frozen_sum");
    rd_end();
    b.clear = 1'b1; tick(1); b.clear = 1'b0;
    chk("t5_running", 32'(b.running), 32'd1);
    rd(0, 0, 3, 32'd0, "t5_cycle_cnt");
    rd(0, 0, 0, 32'd0, "t5_txn_cnt");
    rd(0, 0, 1, 32'd0, "t5_lat_sum");
    rd(0, 0, 2, 32'd0, "t5_lat_max");
    rd_end();

    // 6: reset mid-transaction drops it
    b.ch_cmd[2:0] = 3'd1; tick(1);
    b.ch_cmd[2:0] = 3'd0; tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    b.ch_done[0] = 1'b1; tick(1); b.ch_done[0] = 1'b0;
    b.stop = 1'b1; tick(1); b.stop = 1'b0;
    rd(0, 0, 0, 32'd0, "t6_txn_cnt");
    rd(0, 0, 1, 32'd0, "t6_lat_sum");
    rd(0, 2, 0, 32'd0, "t6_oob_ch");
    rd(0, 15, 3, 32'd2, "t6_cycle_any_ch");
    rd_end();

    chk("sb_drained", 32'(vq.size()), 32'd0);
    chk("sb4_drained", 32'(vq4.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
